// File: rtl/seq_detect_param_pkg.sv
// Shared constants and helpers for the serial pattern detector.
//   PAT_DEFAULT    : pattern loaded at reset (MSB is received first)
//   PAT_W_MIN/MAX  : supported pattern-length range
//   fill_w()       : width of a counter that must hold 0..pat_w
package seq_detect_param_pkg;

   localparam int         PAT_W_MIN   = 2;
   localparam int         PAT_W_MAX   = 16;
   localparam logic [3:0] PAT_DEFAULT = 4'b1010;

   function automatic int fill_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with a synchronous clear.
//   clk     : clock
//   rst_n   : synchronous active-low reset, highest priority
//   i_inc   : count up by one, holding at all-ones
//   i_clr   : clear; when i_inc is also high the result is 1
//   o_cnt   : current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= i_inc ? W'(1) : '0;
      end else if (i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern and a saturating
// match counter.
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset
//   en        : qualifies sampling of in
//   in        : serial data bit
//   pat_load  : load pat_in as the active pattern and restart the history
//   pat_in    : new pattern, MSB is the first bit received
//   cnt_clr   : clear match_cnt
//   out       : registered one-cycle match pulse
//   match_cnt : saturating number of matches
//   fill      : number of valid history bits, 0..PAT_W
// PAT_W must lie within PAT_W_MIN..PAT_W_MAX.
module seq_detect_param
   import seq_detect_param_pkg::*;
#(
   parameter int               PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_DEFAULT),
   parameter bit               OVERLAP  = 1'b1,
   parameter int               CNT_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       in,
   input  logic                       pat_load,
   input  logic [PAT_W-1:0]           pat_in,
   input  logic                       cnt_clr,
   output logic                       out,
   output logic [CNT_W-1:0]           match_cnt,
   output logic [fill_w(PAT_W)-1:0]   fill
);

   localparam int                FILL_W   = fill_w(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  r_hist;
   logic [PAT_W-1:0]  r_pat;
   logic [FILL_W-1:0] r_fill;
   logic              r_out;

   logic [PAT_W-1:0]  w_hist_next;
   logic [FILL_W-1:0] w_fill_next;
   logic              w_match;

   assign w_hist_next = {r_hist[PAT_W-2:0], in};
   assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);

   // Compare against the post-shift history so the pulse lands exactly one
   // cycle after the final bit's sampling edge. A load in the same cycle
   // discards the incoming bit, so it can never produce a match.
   assign w_match = en && !pat_load &&
                    (w_hist_next == r_pat) && (w_fill_next == FILL_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hist <= '0;
         r_pat  <= PAT_INIT;
         r_fill <= '0;
         r_out  <= 1'b0;
      end else if (pat_load) begin
         r_pat  <= pat_in;
         r_fill <= '0;
         r_out  <= 1'b0;
      end else if (en) begin
         r_hist <= w_hist_next;
         // Without overlap the next match must be built from fresh bits.
         r_fill <= (w_match && !OVERLAP) ? '0 : w_fill_next;
         r_out  <= w_match;
      end else begin
         r_out  <= 1'b0;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_match),
      .i_clr (cnt_clr),
      .o_cnt (match_cnt)
   );

   assign out  = r_out;
   assign fill = r_fill;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: three detector instances share one stimulus stream.
//   u_a : default parameters
//   u_b : OVERLAP = 0
//   u_c : CNT_W = 2
module tb_seq_detect_param;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       in;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       cnt_clr;

   logic       a_out, b_out, c_out;
   logic [7:0] a_cnt, b_cnt;
   logic [1:0] c_cnt;
   logic [2:0] a_fill, b_fill, c_fill;

   int n_err;
   int n_chk;

   seq_detect_param u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .out(a_out), .match_cnt(a_cnt),
      .fill(a_fill)
   );

   seq_detect_param #(.OVERLAP(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .out(b_out), .match_cnt(b_cnt),
      .fill(b_fill)
   );

   seq_detect_param #(.CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .out(c_out), .match_cnt(c_cnt),
      .fill(c_fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic b, input logic e);
      in = b;
      en = e;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic [11:0] stream;
   logic [11:0] exp_a;
   logic [11:0] exp_b;
   logic [3:0]  pat4;
   logic [3:0]  exp4;

   initial begin
      n_err    = 0;
      n_chk    = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      in       = 1'b0;
      pat_load = 1'b0;
      pat_in   = 4'b0000;
      cnt_clr  = 1'b0;

      // Reset state
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("rst_out", 32'(a_out), 32'd0);
      chk("rst_cnt", 32'(a_cnt), 32'd0);
      chk("rst_fill", 32'(a_fill), 32'd0);
      chk("rst_cnt_c", 32'(c_cnt), 32'd0);
      rst_n = 1'b1;

      // 1,0 repeated: overlapping pulses after bits 4,6,8,10,12;
      // non-overlapping after bits 4,8,12. Clear meets the 5th match.
      stream = 12'b1010_1010_1010;
      exp_a  = 12'b0001_0101_0101;
      exp_b  = 12'b0001_0001_0001;
      for (int i = 0; i < 12; i++) begin
         cnt_clr = (i == 11);
         step(stream[11-i], 1'b1);
         chk($sformatf("ovl_out_%0d", i + 1), 32'(a_out), 32'(exp_a[11-i]));
         chk($sformatf("novl_out_%0d", i + 1), 32'(b_out), 32'(exp_b[11-i]));
         if (i == 5) begin
            chk("ovl_cnt_6", 32'(a_cnt), 32'd2);
            chk("novl_cnt_6", 32'(b_cnt), 32'd1);
            chk("ovl_fill_6", 32'(a_fill), 32'd4);
            chk("novl_fill_6", 32'(b_fill), 32'd2);
         end
         if (i == 7) begin
            chk("novl_cnt_8", 32'(b_cnt), 32'd2);
            chk("novl_fill_8", 32'(b_fill), 32'd0);
            chk("c_cnt_3rd", 32'(c_cnt), 32'd3);
         end
         if (i == 9) begin
            chk("ovl_cnt_4th", 32'(a_cnt), 32'd4);
            chk("c_sat_4th", 32'(c_cnt), 32'd3);
         end
      end
      chk("c_clr_match", 32'(c_cnt), 32'd1);
      chk("ovl_clr_match", 32'(a_cnt), 32'd1);
      chk("novl_clr_match", 32'(b_cnt), 32'd1);

      // Clear without a match, en low
      cnt_clr = 1'b1;
      step(1'b0, 1'b0);
      cnt_clr = 1'b0;
      chk("clr_only", 32'(a_cnt), 32'd0);
      chk("clr_only_c", 32'(c_cnt), 32'd0);
      chk("en0_out", 32'(a_out), 32'd0);

      // 1,0,1 then a 5-cycle en=0 gap with in=0, then the final 0
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         chk($sformatf("gap_out_%0d", i), 32'(a_out), 32'd0);
         chk($sformatf("gap_fill_%0d", i), 32'(a_fill), 32'd3);
      end
      step(1'b0, 1'b1);
      chk("gap_final_out", 32'(a_out), 32'd1);
      chk("gap_final_cnt", 32'(a_cnt), 32'd1);
      step(1'b0, 1'b0);
      chk("after_pulse_en0", 32'(a_out), 32'd0);

      // 1,0,1 then load 0110 with en=1 and in=0 (would match the old pattern)
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      pat_load = 1'b1;
      pat_in   = 4'b0110;
      step(1'b0, 1'b1);
      pat_load = 1'b0;
      chk("load_out", 32'(a_out), 32'd0);
      chk("load_fill", 32'(a_fill), 32'd0);
      chk("load_cnt", 32'(a_cnt), 32'd0);
      pat4 = 4'b0110;
      exp4 = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         step(pat4[3-i], 1'b1);
         chk($sformatf("newpat_out_%0d", i + 1), 32'(a_out), 32'(exp4[3-i]));
         chk($sformatf("newpat_fill_%0d", i + 1), 32'(a_fill), 32'(i + 1));
      end

      // Reset wins over load, clear and en; pattern returns to 1010
      rst_n    = 1'b0;
      pat_load = 1'b1;
      pat_in   = 4'b1111;
      cnt_clr  = 1'b1;
      step(1'b1, 1'b1);
      chk("rstprio_fill", 32'(a_fill), 32'd0);
      chk("rstprio_cnt", 32'(a_cnt), 32'd0);
      chk("rstprio_out", 32'(a_out), 32'd0);
      pat_load = 1'b0;
      cnt_clr  = 1'b0;
      rst_n    = 1'b1;

      // 1,0,1 then mid-stream reset, then 0: partial match is lost
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      rst_n = 1'b0;
      step(1'b0, 1'b1);
      chk("midrst_fill", 32'(a_fill), 32'd0);
      rst_n = 1'b1;
      step(1'b0, 1'b1);
      chk("midrst_out", 32'(a_out), 32'd0);
      chk("midrst_fill1", 32'(a_fill), 32'd1);
      pat4 = 4'b1010;
      exp4 = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         step(pat4[3-i], 1'b1);
         chk($sformatf("postrst_out_%0d", i + 1), 32'(a_out), 32'(exp4[3-i]));
      end
      chk("postrst_cnt", 32'(a_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
